// File: rtl/pipelined_direct_interc.sv
// Pipelined direct interconnect: a WIDTH-bit valid/ready route through STAGES 2-entry skid slices.
// Optional occupancy counter port: define PIPE_INTERC_OCCUPANCY_EN.

module pipelined_direct_interc_slice #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             accept;
  logic             take;

  // Handshake outputs decode only the state register, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready_o  = (state_q != S_FULL);
  assign out_valid_o = (state_q != S_EMPTY);
  assign out_data_o  = head_q;

  assign accept = in_valid_i && in_ready_o;
  assign take   = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          head_d  = in_data_i;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && take) begin
          head_d = in_data_i;
        end else if (accept) begin
          tail_d  = in_data_i;
          state_d = S_FULL;
        end else if (take) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (take) begin
          head_d  = tail_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

module pipelined_direct_interc #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1,
  localparam int OCC_W = (STAGES == 0) ? 1 : $clog2(2 * STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
`ifdef PIPE_INTERC_OCCUPANCY_EN
  ,
  output logic [OCC_W-1:0] occupancy_o
`endif
);

  generate
    if (STAGES == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_data_o  = in_data_i;
      assign out_valid_o = in_valid_i;
      assign in_ready_o  = out_ready_i;
    end else begin : g_pipe
      logic [WIDTH-1:0] data_s [STAGES+1];
      logic [STAGES:0]  valid_s;
      logic [STAGES:0]  ready_s;

      assign data_s[0]       = in_data_i;
      assign valid_s[0]      = in_valid_i;
      assign in_ready_o      = ready_s[0];
      assign out_data_o      = data_s[STAGES];
      assign out_valid_o     = valid_s[STAGES];
      assign ready_s[STAGES] = out_ready_i;

      for (genvar k = 0; k < STAGES; k++) begin : g_slice
        pipelined_direct_interc_slice #(
          .WIDTH(WIDTH)
        ) u_slice (
          .clk        (clk),
          .rst_n      (rst_n),
          .in_data_i  (data_s[k]),
          .in_valid_i (valid_s[k]),
          .in_ready_o (ready_s[k]),
          .out_data_o (data_s[k+1]),
          .out_valid_o(valid_s[k+1]),
          .out_ready_i(ready_s[k+1])
        );
      end
    end
  endgenerate

`ifdef PIPE_INTERC_OCCUPANCY_EN
  generate
    if (STAGES == 0) begin : g_occ_none
      assign occupancy_o = '0;
    end else begin : g_occ
      logic [OCC_W-1:0] occ_q, occ_d;
      logic             in_xfer;
      logic             out_xfer;

      assign in_xfer     = in_valid_i && in_ready_o;
      assign out_xfer    = out_valid_o && out_ready_i;
      assign occupancy_o = occ_q;

      always_comb begin
        occ_d = occ_q;
        if (in_xfer && !out_xfer) begin
          occ_d = occ_q + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
          occ_d = occ_q - OCC_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          occ_q <= '0;
        end else begin
          occ_q <= occ_d;
        end
      end
    end
  endgenerate
`endif

endmodule
